elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
- Parametrised pipeline boundary register for the ARM core. Intended to replace fixed-width stage registers (ID/EX, EX/MEM, MEM/WB).
- Carries one opaque DATA_W-bit payload bundle per beat.
- Uses a valid/ready handshake, so stalls propagate without external enable logic.
- Provides a synchronous flush that inserts a bubble, plus an optional 2-entry skid buffer that breaks the combinational ready path between stages.

Parameters:
- DATA_W, 152, payload width in bits (packed control plus operand bundle).
- SKID, 1: 1 gives a registered in_ready with a 2-entry skid buffer; 0 gives a single entry with combinational ready pass-through.
- FLUSH_ZERO, 1: 1 clears payload registers on flush; 0 clears only the valid state and keeps data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous bubble insert (branch taken / hazard squash).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream can accept a beat.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of beats held (0..2; max 1 when SKID=0).

Behaviour:
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY, FULL, SKIDFULL. SKIDFULL is unreachable when SKID=0.
- Registers: main_q (DATA_W), skid_q (DATA_W, present only when SKID=1), state.
- Outputs by state:
  - out_valid = (state != EMPTY).
  - out_data = main_q.
  - occupancy: EMPTY=0, FULL=1, SKIDFULL=2.
- in_ready:
  - SKID=1: in_ready = (state != SKIDFULL), a pure register decode.
  - SKID=0: in_ready = (state == EMPTY) | out_ready.
- Reset (async, any state, mid-transfer included): state=EMPTY, main_q=0, skid_q=0, out_valid=0, occupancy=0. in_ready is 1 during reset.
- Transitions (flush=0):
  - EMPTY: in_fire -> FULL, main_q<=in_data. Otherwise stay.
  - FULL, in_fire & out_fire -> FULL, main_q<=in_data (back-to-back throughput of 1 beat/cycle).
  - FULL, out_fire only -> EMPTY. main_q holds.
  - FULL, in_fire only (SKID=1 only) -> SKIDFULL, skid_q<=in_data. With SKID=0 this case cannot occur, because in_ready=0.
  - FULL, neither fire -> hold.
  - SKIDFULL: out_fire -> FULL, main_q<=skid_q. Otherwise hold. in_fire is impossible here.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped except by flush.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY. The SKID=0 pass-through adds no extra latency.
- Flush (highest priority after rst):
  - Next state is EMPTY regardless of current state. Both entries are discarded.
  - Any in_fire or out_fire in the flush cycle: the upstream beat is dropped. The downstream consumer still sees its handshake complete, because out_valid was 1 combinationally; squashing that beat is the consumer's responsibility.
  - FLUSH_ZERO=1: main_q and skid_q are cleared to 0, so downstream decode sees all control bits (including the status-register field) cleared.
  - FLUSH_ZERO=0: data registers hold.
- Simultaneous flush with rst: rst dominates.
- While out_ready=0, out_data and out_valid are stable (AXI-style hold rule). Verification asserts this.
- No X on outputs after reset. in_data is sampled only on in_fire.

Decomposition:
- Shared package pipe_pkg holds:
  - the state typedef (EMPTY/FULL/SKIDFULL, 2-bit encoding 00/01/10);
  - the occupancy constants;
  - per-stage payload width localparams (e.g. ID_EX_W=152), so instantiations agree with the packers.
- No sub-module. The skid entry is a generate branch on SKID.
- Stage-specific bundles (ID/EX field packing) are done by the instantiating stage with concatenation, not inside this block.

Test Plan:
- Reset mid-transfer: assert rst while SKIDFULL -> out_valid=0, occupancy=0, out_data=0, in_ready=1 in the same cycle.
- Streaming (SKID=1): in_valid=1 with data 0x1,0x2,0x3 and out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, one cycle after each input, occupancy constant at 1.
- Backpressure fill: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0 for a 3rd beat (0xC held upstream). Release out_ready -> 0xA, 0xB, 0xC emerge in order, none lost.
- Flush in SKIDFULL with FLUSH_ZERO=1 and a simultaneous in_valid of 0xD -> next cycle state EMPTY, out_valid=0, main_q=0, 0xD never appears.
- SKID=0 pass-through: FULL, out_ready=1, in_valid=1 with 0x5 -> in_ready=1 in that cycle, 0x5 on out_data next cycle. With out_ready=0 -> in_ready=0.
- FLUSH_ZERO=0 flush in FULL holding 0x77 -> out_valid=0, out_data remains 0x77. Next push 0x78 -> out_valid=1 with 0x78.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types: stage-register states, occupancy codes and per-stage payload widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        FULL     = 2'b01,
        SKIDFULL = 2'b10
    } pipe_state_e;

    localparam int unsigned OCC_W = 2;
    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_TWO  = OCC_W'(2);

    // Payload widths shared with the per-stage bundle packers.
    localparam int unsigned ID_EX_W  = 152;
    localparam int unsigned EX_MEM_W = 112;
    localparam int unsigned MEM_WB_W = 72;

    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
        case (s)
            FULL:     return OCC_ONE;
            SKIDFULL: return OCC_TWO;
            default:  return OCC_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/elastic_pipe_reg.sv
// Valid/ready pipeline boundary register with synchronous flush and an optional
// 2-entry skid buffer that registers in_ready.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = ID_EX_W,
    parameter bit          SKID       = 1'b1,
    parameter bit          FLUSH_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_of(state_q);
    assign in_ready  = SKID ? (state_q != SKIDFULL) : ((state_q == EMPTY) | out_ready);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and data-path selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_ZERO) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && SKID) begin
                        state_d = SKIDFULL;
                        skid_d  = in_data;
                    end
                end
                SKIDFULL: begin
                    if (out_fire) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // Second entry exists only when the ready path must be registered.
    if (SKID) begin : g_skid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_q <= '0;
            end else begin
                skid_q <= skid_d;
            end
        end
    end else begin : g_no_skid
        assign skid_q = '0;
    end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench for elastic_pipe_reg: three configurations driven with random and
// directed traffic, each checked against a bounded-FIFO reference model.
module tb_elastic_pipe_reg;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   phase;
    int   n_chk;
    int   n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        // g0: skid + zeroing flush, g1: pass-through, g2: skid + data-keeping flush
        localparam bit SK = (g != 1);
        localparam bit FZ = (g != 2);
        localparam int unsigned CAP = SK ? 2 : 1;

        logic          flush, in_valid, in_ready, out_valid, out_ready;
        logic [W-1:0]  in_data, out_data;
        logic [1:0]    occupancy;

        logic [W-1:0]  q[$];
        logic [W-1:0]  hold;
        logic [W-1:0]  head_seen;
        logic          p_valid, p_ready, p_flush;
        logic [W-1:0]  p_data;

        elastic_pipe_reg #(.DATA_W(W), .SKID(SK), .FLUSH_ZERO(FZ)) u_dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
            .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
            .occupancy(occupancy)
        );

        // Driver: inputs change just after the rising edge.
        initial begin
            int cyc;
            int mode;
            cyc = 0;
            mode = 0;
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                if (cyc % 16 == 0) mode = int'($urandom_range(0, 2));
                case (phase)
                    1, 5: begin
                        in_valid  = ($urandom_range(0, 3) != 0);
                        in_data   = W'($urandom);
                        flush     = ($urandom_range(0, 19) == 0);
                        out_ready = (mode == 0) ? 1'b1 :
                                    (mode == 1) ? 1'($urandom_range(0, 1)) :
                                                  ($urandom_range(0, 4) == 0);
                    end
                    2: begin
                        in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'b0; flush = 1'b0;
                    end
                    3: begin
                        in_valid = 1'b1; in_data = W'(32'hD); out_ready = 1'b0; flush = 1'b1;
                    end
                    default: begin
                        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
                    end
                endcase
            end
        end

        // Monitor: compares DUT against model before the coming edge, pops on out_fire.
        always @(negedge clk) begin
            logic [W-1:0] v;
            if (rst) begin
                p_valid = 1'b0;
            end else begin
                head_seen = (q.size() != 0) ? q[0] : hold;
                chk($sformatf("cfg%0d occupancy", g), W'(occupancy), W'(q.size()));
                chk($sformatf("cfg%0d out_valid", g), W'(out_valid), W'(q.size() != 0));
                chk($sformatf("cfg%0d in_ready", g), W'(in_ready),
                    W'(SK ? (q.size() < CAP) : ((q.size() == 0) || out_ready)));
                chk($sformatf("cfg%0d out_data", g), out_data, head_seen);
                if (p_valid && !p_ready && !p_flush) begin
                    chk($sformatf("cfg%0d stall_valid", g), W'(out_valid), W'(1));
                    chk($sformatf("cfg%0d stall_data", g), out_data, p_data);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("cfg%0d spurious_beat", g), out_data, hold);
                    end else begin
                        v = q.pop_front();
                        if (q.size() == 0) hold = v;
                    end
                end
                p_valid = out_valid; p_ready = out_ready; p_flush = flush; p_data = out_data;
            end
        end

        // Predictor: records accepted beats, applies flush to the model.
        always @(negedge clk) begin
            #1;
            if (!rst) begin
                if (flush) begin
                    hold = FZ ? '0 : head_seen;
                    q.delete();
                end else if (in_valid && in_ready) begin
                    q.push_back(in_data);
                end
            end
        end

        // Asynchronous reset takes effect without waiting for a clock edge.
        always @(posedge rst) begin
            q.delete();
            hold = '0;
            #1;
            chk($sformatf("cfg%0d rst out_valid", g), W'(out_valid), W'(0));
            chk($sformatf("cfg%0d rst occupancy", g), W'(occupancy), W'(0));
            chk($sformatf("cfg%0d rst out_data", g), out_data, W'(0));
            chk($sformatf("cfg%0d rst in_ready", g), W'(in_ready), W'(1));
        end
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        phase = 0;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        phase = 1;
        repeat (1500) @(posedge clk);
        phase = 2;
        repeat (3) @(posedge clk);
        phase = 3;
        @(posedge clk);
        phase = 2;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        phase = 0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        phase = 5;
        repeat (1000) @(posedge clk);
        phase = 0;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
